// File: rtl/bp_fe_fetch_buffer.sv
// Fetch decoupling buffer between the PC generator and the I$. It reserves a slot
// for every I$ request, pairs responses with their PCs in order, and poisons in-flight fetches on flush.
module bp_fe_fetch_buffer_chk #(
  parameter int ptr_width_lp = 5
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  input logic                    icache_data_v_i,
  input logic                    icache_miss_i,
  input logic                    resp_s,
  input logic                    outstanding_s,
  input logic                    fetch_yumi_i,
  input logic                    fetch_v_o,
  input logic                    poisoned_s,
  input logic [ptr_width_lp-1:0] rptr_r,
  input logic [ptr_width_lp-1:0] resp_ptr_r
);

  a_no_data_and_miss: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(icache_data_v_i && icache_miss_i));

  a_no_stray_resp: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    resp_s |-> outstanding_s);

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fetch_yumi_i |-> fetch_v_o);

  a_poison_aligned: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    poisoned_s |-> (rptr_r == resp_ptr_r));

endmodule

module bp_fe_fetch_buffer #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int els_p         = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [vaddr_width_p-1:0] req_vaddr_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  output logic [vaddr_width_p-1:0] icache_vaddr_o,
  output logic                     icache_vaddr_v_o,
  input  logic                     icache_vaddr_ready_i,
  input  logic [instr_width_p-1:0] icache_data_i,
  input  logic                     icache_data_v_i,
  input  logic                     icache_miss_i,
  input  logic                     flush_i,
  output logic [vaddr_width_p-1:0] fetch_pc_o,
  output logic [instr_width_p-1:0] fetch_instr_o,
  output logic                     fetch_miss_o,
  output logic                     fetch_v_o,
  input  logic                     fetch_yumi_i
);

  localparam int idx_width_lp = $clog2(els_p);
  localparam int ptr_width_lp = idx_width_lp + 1;
  localparam logic [ptr_width_lp-1:0] els_lp  = ptr_width_lp'(els_p);
  localparam logic [ptr_width_lp-1:0] one_lp  = ptr_width_lp'(1);
  localparam logic [ptr_width_lp-1:0] zero_lp = {ptr_width_lp{1'b0}};

  logic [ptr_width_lp-1:0] wptr_r, rptr_r, resp_ptr_r, poison_cnt_r;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, resp_ptr_n, poison_cnt_n;
  logic [ptr_width_lp-1:0] occupancy_s, resp_ptr_next_s;
  logic                    credit_s, accept_s, resp_s, outstanding_s, resp_valid_s;
  logic                    poisoned_s, consume_s, resp_we_s;

  logic [vaddr_width_p-1:0] pc_mem_r    [els_p];
  logic [instr_width_p-1:0] instr_mem_r [els_p];
  logic [els_p-1:0]         miss_mem_r;

  // Credits come from registered pointers only, so a same-cycle yumi never frees a slot.
  assign occupancy_s      = wptr_r - rptr_r;
  assign credit_s         = occupancy_s < els_lp;
  assign poisoned_s       = poison_cnt_r != zero_lp;
  assign icache_vaddr_o   = req_vaddr_i;
  assign icache_vaddr_v_o = reset_n_i & req_v_i & credit_s & ~flush_i;
  assign req_ready_o      = reset_n_i & icache_vaddr_ready_i & credit_s & ~flush_i;
  assign accept_s         = req_v_i & req_ready_o;

  assign resp_s          = icache_data_v_i | icache_miss_i;
  assign outstanding_s   = (resp_ptr_r != wptr_r) | poisoned_s;
  assign resp_valid_s    = resp_s & outstanding_s;
  assign resp_ptr_next_s = resp_valid_s ? (resp_ptr_r + one_lp) : resp_ptr_r;
  assign resp_we_s       = resp_valid_s & ~poisoned_s & ~flush_i;

  assign fetch_v_o     = (rptr_r != resp_ptr_r) & ~poisoned_s;
  assign consume_s     = fetch_yumi_i & fetch_v_o;
  assign fetch_pc_o    = pc_mem_r[rptr_r[idx_width_lp-1:0]];
  assign fetch_instr_o = instr_mem_r[rptr_r[idx_width_lp-1:0]];
  assign fetch_miss_o  = miss_mem_r[rptr_r[idx_width_lp-1:0]];

  // Next-state for pointers and poison count; flush overrides accept and yumi.
  always_comb begin
    wptr_n       = wptr_r;
    rptr_n       = rptr_r;
    resp_ptr_n   = resp_ptr_r;
    poison_cnt_n = poison_cnt_r;
    if (flush_i) begin
      rptr_n       = resp_ptr_next_s;
      resp_ptr_n   = resp_ptr_next_s;
      poison_cnt_n = wptr_r - resp_ptr_next_s;
    end else begin
      if (accept_s) begin
        wptr_n = wptr_r + one_lp;
      end else begin
        wptr_n = wptr_r;
      end
      // A poisoned response retires its slot from the head as well.
      if (resp_valid_s && poisoned_s) begin
        poison_cnt_n = poison_cnt_r - one_lp;
        resp_ptr_n   = resp_ptr_r + one_lp;
        rptr_n       = rptr_r + one_lp;
      end else if (resp_valid_s) begin
        resp_ptr_n = resp_ptr_r + one_lp;
      end else begin
        resp_ptr_n = resp_ptr_r;
      end
      if (consume_s) begin
        rptr_n = rptr_r + one_lp;
      end else begin
        rptr_n = rptr_n;
      end
    end
  end

  // Pointer and poison state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r       <= zero_lp;
      rptr_r       <= zero_lp;
      resp_ptr_r   <= zero_lp;
      poison_cnt_r <= zero_lp;
    end else begin
      wptr_r       <= wptr_n;
      rptr_r       <= rptr_n;
      resp_ptr_r   <= resp_ptr_n;
      poison_cnt_r <= poison_cnt_n;
    end
  end

  // Entry storage; contents are qualified by the pointers, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (accept_s) begin
      pc_mem_r[wptr_r[idx_width_lp-1:0]] <= req_vaddr_i;
    end
    if (resp_we_s) begin
      instr_mem_r[resp_ptr_r[idx_width_lp-1:0]] <= icache_data_i;
      miss_mem_r[resp_ptr_r[idx_width_lp-1:0]]  <= icache_miss_i;
    end
  end

  bp_fe_fetch_buffer_chk #(.ptr_width_lp(ptr_width_lp)) chk (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .icache_data_v_i (icache_data_v_i),
    .icache_miss_i   (icache_miss_i),
    .resp_s          (resp_s),
    .outstanding_s   (outstanding_s),
    .fetch_yumi_i    (fetch_yumi_i),
    .fetch_v_o       (fetch_v_o),
    .poisoned_s      (poisoned_s),
    .rptr_r          (rptr_r),
    .resp_ptr_r      (resp_ptr_r)
  );

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Directed self-checking bench for bp_fe_fetch_buffer: in-order delivery, full/credit
// behaviour, misses, flush poisoning and asynchronous reset.
module tb_bp_fe_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [38:0] req_vaddr;
  logic        req_v;
  logic        req_ready;
  logic [38:0] icache_vaddr;
  logic        icache_vaddr_v;
  logic        icache_vaddr_ready;
  logic [31:0] icache_data;
  logic        icache_data_v;
  logic        icache_miss;
  logic        flush;
  logic [38:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_miss;
  logic        fetch_v;
  logic        fetch_yumi;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bp_fe_fetch_buffer dut (
    .clk_i                (clk),
    .reset_n_i            (reset_n),
    .req_vaddr_i          (req_vaddr),
    .req_v_i              (req_v),
    .req_ready_o          (req_ready),
    .icache_vaddr_o       (icache_vaddr),
    .icache_vaddr_v_o     (icache_vaddr_v),
    .icache_vaddr_ready_i (icache_vaddr_ready),
    .icache_data_i        (icache_data),
    .icache_data_v_i      (icache_data_v),
    .icache_miss_i        (icache_miss),
    .flush_i              (flush),
    .fetch_pc_o           (fetch_pc),
    .fetch_instr_o        (fetch_instr),
    .fetch_miss_o         (fetch_miss),
    .fetch_v_o            (fetch_v),
    .fetch_yumi_i         (fetch_yumi)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [38:0] pc);
    req_vaddr = pc;
    req_v     = 1'b1;
    #1;
    check("req_ready", 64'(req_ready), 64'(1'b1));
    step();
    req_v = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic m);
    icache_data   = d;
    icache_data_v = ~m;
    icache_miss   = m;
    step();
    icache_data_v = 1'b0;
    icache_miss   = 1'b0;
  endtask

  task automatic consume(input string tag, input logic [38:0] pc, input logic [31:0] instr,
                         input logic m);
    check({tag, "_v"}, 64'(fetch_v), 64'(1'b1));
    check({tag, "_pc"}, 64'(fetch_pc), 64'(pc));
    check({tag, "_miss"}, 64'(fetch_miss), 64'(m));
    if (!m) begin
      check({tag, "_instr"}, 64'(fetch_instr), 64'(instr));
    end
    fetch_yumi = 1'b1;
    step();
    fetch_yumi = 1'b0;
  endtask

  task automatic count_accepts(input logic [38:0] base, output int acc);
    logic rdy;
    acc   = 0;
    req_v = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_vaddr = base + 39'(4 * acc);
      #1;
      rdy = req_ready;
      step();
      if (rdy) acc++;
    end
  endtask

  initial begin
    int acc;
    reset_n            = 1'b0;
    req_vaddr          = 39'h0;
    req_v              = 1'b1;
    icache_vaddr_ready = 1'b1;
    icache_data        = 32'h0;
    icache_data_v      = 1'b0;
    icache_miss        = 1'b0;
    flush              = 1'b0;
    fetch_yumi         = 1'b0;

    // reset state
    #3;
    check("rst_req_ready", 64'(req_ready), 64'(1'b0));
    check("rst_vaddr_v", 64'(icache_vaddr_v), 64'(1'b0));
    check("rst_fetch_v", 64'(fetch_v), 64'(1'b0));
    #20;
    reset_n = 1'b1;
    req_v   = 1'b0;
    step();

    // four sequential hits, packet one cycle after each response
    req_vaddr = 39'h8000_0000;
    req_v     = 1'b1;
    #1;
    check("vaddr_pass", 64'(icache_vaddr), 64'(39'h8000_0000));
    check("vaddr_v", 64'(icache_vaddr_v), 64'(1'b1));
    req_v = 1'b0;
    for (int k = 0; k < 4; k++) request(39'h8000_0000 + 39'(4 * k));
    for (int k = 0; k < 4; k++) begin
      icache_data   = 32'h1111_0000 + 32'(k);
      icache_data_v = 1'b1;
      #1;
      check("lat_not_yet", 64'(fetch_v), 64'(1'b0));
      step();
      icache_data_v = 1'b0;
      consume("seq", 39'h8000_0000 + 39'(4 * k), 32'h1111_0000 + 32'(k), 1'b0);
    end
    check("seq_empty", 64'(fetch_v), 64'(1'b0));

    // fill to capacity, then one yumi frees exactly one credit next cycle
    count_accepts(39'h1000, acc);
    check("full_accepts", 64'(acc), 64'(16));
    #1;
    check("full_ready", 64'(req_ready), 64'(1'b0));
    check("full_vaddr_v", 64'(icache_vaddr_v), 64'(1'b0));
    req_v = 1'b0;
    for (int i = 0; i < 16; i++) respond(32'hC000_0000 + 32'(i), 1'b0);
    req_v      = 1'b1;
    req_vaddr  = 39'h1040;
    fetch_yumi = 1'b1;
    #1;
    check("no_bypass", 64'(req_ready), 64'(1'b0));
    step();
    fetch_yumi = 1'b0;
    #1;
    check("credit_back", 64'(req_ready), 64'(1'b1));
    step();
    req_v = 1'b0;
    #1;
    check("refull_ready", 64'(req_ready), 64'(1'b0));
    respond(32'hC000_0010, 1'b0);
    for (int j = 0; j < 16; j++) consume("drain", 39'h1004 + 39'(4 * j), 32'hC000_0001 + 32'(j), 1'b0);
    check("drain_empty", 64'(fetch_v), 64'(1'b0));

    // miss packet followed in order by a hit
    request(39'h80);
    request(39'h84);
    respond(32'h0, 1'b1);
    respond(32'hDEAD_0084, 1'b0);
    consume("miss", 39'h80, 32'h0, 1'b1);
    consume("after_miss", 39'h84, 32'hDEAD_0084, 1'b0);

    // flush with 2 buffered and 3 in flight
    for (int k = 0; k < 5; k++) request(39'h100 + 39'(4 * k));
    respond(32'hF100, 1'b0);
    respond(32'hF104, 1'b0);
    check("pre_flush_v", 64'(fetch_v), 64'(1'b1));
    flush      = 1'b1;
    req_v      = 1'b1;
    req_vaddr  = 39'h300;
    fetch_yumi = 1'b1;
    #1;
    check("flush_ready", 64'(req_ready), 64'(1'b0));
    check("flush_vaddr_v", 64'(icache_vaddr_v), 64'(1'b0));
    step();
    flush      = 1'b0;
    req_v      = 1'b0;
    fetch_yumi = 1'b0;
    check("post_flush_v", 64'(fetch_v), 64'(1'b0));
    check("poison3", 64'(dut.poison_cnt_r), 64'(3));
    for (int k = 0; k < 3; k++) begin
      respond(32'hBAD0_0000 + 32'(k), 1'b0);
      check("drop_v", 64'(fetch_v), 64'(1'b0));
    end
    check("poison_done", 64'(dut.poison_cnt_r), 64'(0));
    request(39'h200);
    step();
    respond(32'h0000_0200, 1'b0);
    consume("post_flush", 39'h200, 32'h0000_0200, 1'b0);
    check("post_flush_empty", 64'(fetch_v), 64'(1'b0));

    // response coincident with flush is discarded
    for (int k = 0; k < 3; k++) request(39'h400 + 39'(4 * k));
    respond(32'hA400, 1'b0);
    icache_data   = 32'hBAD4;
    icache_data_v = 1'b1;
    flush         = 1'b1;
    step();
    icache_data_v = 1'b0;
    flush         = 1'b0;
    check("coin_v", 64'(fetch_v), 64'(1'b0));
    check("coin_poison", 64'(dut.poison_cnt_r), 64'(1));
    respond(32'hBAD8, 1'b0);
    check("coin_drop_v", 64'(fetch_v), 64'(1'b0));
    check("coin_poison0", 64'(dut.poison_cnt_r), 64'(0));
    step();
    check("coin_no_stale", 64'(fetch_v), 64'(1'b0));
    request(39'h500);
    step();
    respond(32'h0000_0500, 1'b0);
    consume("coin_next", 39'h500, 32'h0000_0500, 1'b0);

    // asynchronous reset mid-stream with 5 entries buffered
    for (int k = 0; k < 5; k++) request(39'h600 + 39'(4 * k));
    for (int k = 0; k < 5; k++) respond(32'h0600_0000 + 32'(k), 1'b0);
    check("pre_rst_v", 64'(fetch_v), 64'(1'b1));
    #2;
    reset_n = 1'b0;
    req_v   = 1'b1;
    #1;
    check("arst_fetch_v", 64'(fetch_v), 64'(1'b0));
    check("arst_ready", 64'(req_ready), 64'(1'b0));
    check("arst_vaddr_v", 64'(icache_vaddr_v), 64'(1'b0));
    req_v = 1'b0;
    #10;
    reset_n = 1'b1;
    step();
    check("rel_fetch_v", 64'(fetch_v), 64'(1'b0));
    count_accepts(39'h700, acc);
    check("rel_credits", 64'(acc), 64'(16));
    req_v = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
